// File: rtl/mul_sequencer.sv
// Sequencer for a shift-and-add multiply on a bit-slice datapath: LOAD Q, clear the
// high half, run 64 or 32 add/pass-and-shift steps, then pulse done.
module mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic        m32,
  input  logic        q0,
  input  logic [12:0] iss_step,
  output logic [8:0]  Ialu,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic        C0,
  output logic        mode32,
  output logic [12:0] Iss,
  output logic        nCEM,
  output logic        nCEN,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [8:0] IALU_NOP   = 9'o117;
  localparam logic [8:0] IALU_LOADQ = 9'o037;
  localparam logic [8:0] IALU_CLR   = 9'o344;
  localparam logic [8:0] IALU_ADDAB = 9'o401;
  localparam logic [8:0] IALU_ADDZB = 9'o403;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic       m32_q, m32_d;

  // State, step counter and latched operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      ra_q    <= 4'd0;
      rb_q    <= 4'd0;
      m32_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      m32_q   <= m32_d;
    end
  end

  // Next-state logic; abort beats any pending start, so nothing is latched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    m32_d   = m32_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            ra_d    = ra;
            rb_d    = rb;
            m32_d   = m32;
            cnt_d   = m32 ? 6'd31 : 6'd63;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD:  state_d = S_CLEAR;
        S_CLEAR: state_d = S_STEP;
        S_STEP: begin
          if (cnt_q == 6'd0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  // Output decode from registered state; only q0 and iss_step feed through in STEP.
  always_comb begin
    Ialu   = IALU_NOP;
    A      = ra_q;
    B      = rb_q;
    C0     = 1'b0;
    mode32 = m32_q;
    Iss    = 13'd0;
    nCEM   = 1'b1;
    nCEN   = 1'b1;
    busy   = 1'b1;
    done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        A    = ra;
        B    = rb;
        busy = 1'b0;
      end
      S_LOAD:  Ialu = IALU_LOADQ;
      S_CLEAR: Ialu = IALU_CLR;
      S_STEP: begin
        Ialu = q0 ? IALU_ADDAB : IALU_ADDZB;
        Iss  = iss_step;
        nCEN = (cnt_q == 6'd0) ? 1'b0 : 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized bench for mul_sequencer against a cycle-offset reference model.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [3:0]  ra, rb;
  logic        m32, q0;
  logic [12:0] iss_step;
  logic [8:0]  Ialu;
  logic [3:0]  A, B;
  logic        C0, mode32, nCEM, nCEN, busy, done;
  logic [12:0] Iss;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int ncen_cnt = 0;
  int step_cnt = 0;
  bit alt_q0 = 1'b0;

  // Reference model: t counts cycles since the accepted start (1 = LOAD).
  bit         m_active = 1'b0;
  int         m_t = 0;
  int         m_n = 64;
  logic [3:0] m_ra = 4'd0, m_rb = 4'd0;
  logic       m_m32 = 1'b0;

  mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ra(ra), .rb(rb), .m32(m32), .q0(q0), .iss_step(iss_step),
    .Ialu(Ialu), .A(A), .B(B), .C0(C0), .mode32(mode32), .Iss(Iss),
    .nCEM(nCEM), .nCEN(nCEN), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick(input logic st, input logic ab, input logic rs);
    int ph;
    logic [8:0] e_ialu;
    start = st; abort = ab; reset = rs;
    if (!st) begin
      ra = 4'($urandom); rb = 4'($urandom); m32 = 1'($urandom);
    end
    q0 = alt_q0 ? ~q0 : 1'($urandom);
    iss_step = 13'($urandom);
    #1;
    if (!m_active)          ph = 0;
    else if (m_t == 1)      ph = 1;
    else if (m_t == 2)      ph = 2;
    else if (m_t <= m_n + 2) ph = 3;
    else                    ph = 4;
    case (ph)
      1:       e_ialu = 9'o037;
      2:       e_ialu = 9'o344;
      3:       e_ialu = q0 ? 9'o401 : 9'o403;
      default: e_ialu = 9'o117;
    endcase
    chk("Ialu",   32'(Ialu),   32'(e_ialu));
    chk("A",      32'(A),      32'(ph == 0 ? ra : m_ra));
    chk("B",      32'(B),      32'(ph == 0 ? rb : m_rb));
    chk("C0",     32'(C0),     32'd0);
    chk("mode32", 32'(mode32), 32'(m_m32));
    chk("Iss",    32'(Iss),    32'(ph == 3 ? iss_step : 13'd0));
    chk("nCEM",   32'(nCEM),   32'd1);
    chk("nCEN",   32'(nCEN),   32'((ph == 3 && (m_t - 2) == m_n) ? 1'b0 : 1'b1));
    chk("busy",   32'(busy),   32'(ph != 0));
    chk("done",   32'(done),   32'(ph == 4));
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (nCEN === 1'b0) ncen_cnt++;
    if (busy === 1'b1 && (Ialu === 9'o401 || Ialu === 9'o403)) step_cnt++;
    @(posedge clk);
    if (reset) begin
      m_active = 1'b0; m_ra = 4'd0; m_rb = 4'd0; m_m32 = 1'b0;
    end else if (abort) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_t = 1; m_n = m32 ? 32 : 64;
        m_ra = ra; m_rb = rb; m_m32 = m32;
      end
    end else begin
      m_t++;
      if (m_t > m_n + 3) m_active = 1'b0;
    end
    cyc++;
    #1;
  endtask

  // One multiply: optional abort/reset/extra start at a given step number (0 = none).
  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic m,
                     input int abort_at, input int reset_at, input int start_at,
                     input bit start_in_done, input int exp_lat, input int exp_done);
    int s, n, o, d0, nc0, sc0;
    n = m ? 32 : 64;
    d0 = done_cnt; nc0 = ncen_cnt; sc0 = step_cnt;
    s = cyc;
    ra = a; rb = b; m32 = m;
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < n + 5; k++) begin
      o = cyc - s;
      tick((start_at > 0 && o == 2 + start_at) || (start_in_done && (o == n + 3 || o == n + 4)),
           abort_at > 0 && o == 2 + abort_at,
           reset_at > 0 && o == 2 + reset_at);
    end
    chk("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
    if (exp_lat > 0) begin
      chk("latency", 32'(last_done_cyc - s), 32'(exp_lat));
      chk("ncen_count", 32'(ncen_cnt - nc0), 32'd1);
      chk("step_count", 32'(step_cnt - sc0), 32'(n));
    end
    for (int k = 0; k < 200 && m_active; k++) tick(1'b0, 1'b0, 1'b0);
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    ra = 4'd0; rb = 4'd0; m32 = 1'b0; q0 = 1'b0; iss_step = 13'd0;
    @(posedge clk);
    #1;
    // Held in reset with start/abort toggling, then the first cycle out of reset.
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);

    // Full 64-step run; done 67 cycles after the start cycle.
    run(4'd1, 4'd2, 1'b0, 0, 0, 0, 1'b0, 67, 1);
    // 32-step run with q0 alternating every step.
    alt_q0 = 1'b1;
    run(4'd5, 4'd9, 1'b1, 0, 0, 0, 1'b0, 35, 1);
    alt_q0 = 1'b0;
    // Starts at step 10 and during DONE ignored; start right after DONE accepted.
    run(4'd3, 4'd4, 1'b1, 0, 0, 10, 1'b1, 35, 1);
    // Abort at step 5, then reset at step 20: no done pulse either time.
    run(4'd7, 4'd8, 1'b0, 5, 0, 0, 1'b0, 0, 0);
    run(4'd14, 4'd11, 1'b1, 0, 20, 0, 1'b0, 0, 0);
    chk("mode32_after_reset", 32'(mode32), 32'd0);

    // start and abort together in IDLE: stays idle.
    tick(1'b1, 1'b1, 1'b0);
    chk("start_abort_idle", 32'(busy), 32'd0);

    // Random traffic.
    for (int k = 0; k < 600; k++)
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
